// File: rtl/rs_unified_age.sv
// Unified age-ordered reservation station: SS-wide dispatch and CDB wakeup,
// oldest-ready select per FU class with valid/ready issue, flush and free count.
module rs_unified_age #(
  parameter int SS        = 2,
  parameter int DEPTH     = 8,
  parameter int NUM_FU    = 3,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 64,
  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [SS-1:0]                       disp_valid,
  output logic                                disp_ready,
  input  logic [SS-1:0][PREG_W-1:0]           disp_ps1,
  input  logic [SS-1:0][PREG_W-1:0]           disp_ps2,
  input  logic [SS-1:0]                       disp_rdy1,
  input  logic [SS-1:0]                       disp_rdy2,
  input  logic [SS-1:0][FW-1:0]               disp_fu,
  input  logic [SS-1:0][PAYLOAD_W-1:0]        disp_payload,
  input  logic [SS-1:0]                       cdb_valid,
  input  logic [SS-1:0][PREG_W-1:0]           cdb_preg,
  output logic [NUM_FU-1:0]                   iss_valid,
  input  logic [NUM_FU-1:0]                   iss_ready,
  output logic [NUM_FU-1:0][PREG_W-1:0]       iss_ps1,
  output logic [NUM_FU-1:0][PREG_W-1:0]       iss_ps2,
  output logic [NUM_FU-1:0][PAYLOAD_W-1:0]    iss_payload,
  output logic [CW-1:0]                       free_count
);

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     rdy1;
  logic [DEPTH-1:0]     rdy2;
  logic [PREG_W-1:0]    ps1 [DEPTH];
  logic [PREG_W-1:0]    ps2 [DEPTH];
  logic [FW-1:0]        fu [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];
  logic [DEPTH-1:0]     older [DEPTH];

  logic [NUM_FU-1:0][DEPTH-1:0] cand;
  logic [NUM_FU-1:0][DEPTH-1:0] sel;
  logic [DEPTH-1:0]             leave;
  logic [SS-1:0][DEPTH-1:0]     alloc;
  logic [SS-1:0][DEPTH-1:0]     row;
  logic [DEPTH-1:0]             avail;
  logic [DEPTH-1:0]             taken;
  logic                         found;
  logic                         do_disp;
  logic [CW-1:0]                n_leave;
  logic [CW-1:0]                n_alloc;

  function automatic logic woken(
    input logic [PREG_W-1:0]         p,
    input logic [SS-1:0]             cv,
    input logic [SS-1:0][PREG_W-1:0] cp
  );
    logic hit;
    hit = (p == '0);
    for (int j = 0; j < SS; j++)
      if (cv[j] && cp[j] == p) hit = 1'b1;
    return hit;
  endfunction

  assign disp_ready = (free_count >= CW'(SS));

  // An entry wins FU k when no older entry competes for the same class.
  always_comb begin
    cand        = '0;
    sel         = '0;
    leave       = '0;
    iss_valid   = '0;
    iss_ps1     = '0;
    iss_ps2     = '0;
    iss_payload = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int e = 0; e < DEPTH; e++)
        cand[k][e] = valid[e] & rdy1[e] & rdy2[e] & (fu[e] == FW'(k));
      for (int e = 0; e < DEPTH; e++)
        sel[k][e] = cand[k][e] & ~|(older[e] & cand[k]);
      iss_valid[k] = (|cand[k]) & ~flush;
      for (int e = 0; e < DEPTH; e++)
        if (sel[k][e]) begin
          iss_ps1[k]     |= ps1[e];
          iss_ps2[k]     |= ps2[e];
          iss_payload[k] |= payload[e];
        end
      if (iss_valid[k] && iss_ready[k]) leave |= sel[k];
    end
  end

  // Slots freed by issue this cycle are not reused until next cycle.
  always_comb begin
    do_disp = disp_ready & ~flush;
    avail   = ~valid;
    taken   = '0;
    alloc   = '0;
    row     = '0;
    found   = 1'b0;
    for (int i = 0; i < SS; i++) begin
      row[i] = (valid & ~leave) | taken;
      found  = 1'b0;
      if (do_disp && disp_valid[i])
        for (int e = 0; e < DEPTH; e++)
          if (avail[e] && !found) begin
            alloc[i][e] = 1'b1;
            found       = 1'b1;
          end
      avail = avail & ~alloc[i];
      taken = taken | alloc[i];
    end
  end

  always_comb begin
    n_leave = '0;
    n_alloc = '0;
    for (int e = 0; e < DEPTH; e++) begin
      n_leave = n_leave + CW'(leave[e]);
      n_alloc = n_alloc + CW'(taken[e]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= '0;
      free_count <= CW'(DEPTH);
      for (int e = 0; e < DEPTH; e++) older[e] <= '0;
    end else if (flush) begin
      valid      <= '0;
      free_count <= CW'(DEPTH);
      for (int e = 0; e < DEPTH; e++) older[e] <= '0;
    end else begin
      valid      <= (valid & ~leave) | taken;
      free_count <= free_count + n_leave - n_alloc;
      for (int r = 0; r < DEPTH; r++) older[r] <= older[r] & ~leave;
      for (int i = 0; i < SS; i++)
        for (int e = 0; e < DEPTH; e++)
          if (alloc[i][e]) older[e] <= row[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      rdy1[e] <= rdy1[e] | woken(ps1[e], cdb_valid, cdb_preg);
      rdy2[e] <= rdy2[e] | woken(ps2[e], cdb_valid, cdb_preg);
      for (int i = 0; i < SS; i++)
        if (alloc[i][e]) begin
          ps1[e]     <= disp_ps1[i];
          ps2[e]     <= disp_ps2[i];
          fu[e]      <= disp_fu[i];
          payload[e] <= disp_payload[i];
          rdy1[e]    <= disp_rdy1[i] | woken(disp_ps1[i], cdb_valid, cdb_preg);
          rdy2[e]    <= disp_rdy2[i] | woken(disp_ps2[i], cdb_valid, cdb_preg);
        end
    end
  end

  a_free_bound: assert property (@(posedge clk) disable iff (rst)
    free_count <= CW'(DEPTH));

endmodule
